// File: rtl/sync_fifo_param.sv
// ============================================================================
//  Module   : sync_fifo_param
//  Brief    : Parametrised single-clock FIFO with a full-depth occupancy
//             counter, same-cycle read/write, programmable almost-full /
//             almost-empty thresholds, synchronous flush and registered
//             overflow/underflow reporting.
//  Options  : SYNC_FIFO_STICKY_ERR_EN - when defined, overflow/underflow
//             latch high until reset or flush; otherwise they pulse for one
//             cycle after each rejected request.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   data_counter,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                c_DEPTH     = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_DEPTH_CNT = (ADDR_WIDTH+1)'(c_DEPTH);
  localparam logic [ADDR_WIDTH:0] c_AF_LEVEL  = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] c_AE_LEVEL  = (ADDR_WIDTH+1)'(AE_LEVEL);

  // Storage: not reset, only ever read at positions that were written.
  logic [DATA_WIDTH-1:0] mem_q [c_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic w_full;
  logic w_empty;
  logic w_wr_accept;
  logic w_rd_accept;

  // Flags decode the occupancy counter only; full/empty come from pre-edge state,
  // so a full FIFO never accepts a write and an empty one never a read.
  assign w_full  = (count_q == c_DEPTH_CNT);
  assign w_empty = (count_q == '0);

  // Flush suppresses both requests in the cycle it is asserted.
  assign w_wr_accept = wr_en & ~w_full  & ~flush;
  assign w_rd_accept = rd_en & ~w_empty & ~flush;

  // Next-state computation for pointers, occupancy, read port and error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    rd_valid_d  = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    if (flush) begin
      // Memory and data_out deliberately keep their contents.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_wr_accept) begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (w_rd_accept) begin
        rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
        data_out_d = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      case ({w_wr_accept, w_rd_accept})
        2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
        2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
        default: count_d = count_q;
      endcase
`ifdef SYNC_FIFO_STICKY_ERR_EN
      overflow_d  = overflow_q  | (wr_en & w_full);
      underflow_d = underflow_q | (rd_en & w_empty);
`else
      overflow_d  = wr_en & w_full;
      underflow_d = rd_en & w_empty;
`endif
    end
  end

  // Control and read-port state, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out     = data_out_q;
  assign rd_valid     = rd_valid_q;
  assign data_counter = count_q;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (count_q >= c_AF_LEVEL);
  assign almost_empty = (count_q <= c_AE_LEVEL);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
//  Module   : tb_sync_fifo_param
//  Brief    : Self-checking bench for sync_fifo_param using a queue-based
//             reference model and randomized traffic. Honours
//             SYNC_FIFO_STICKY_ERR_EN the same way the design does.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = 14;
  localparam int AEL   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   data_counter;
  logic          overflow;
  logic          underflow;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_rv;
  logic          m_ovf;
  logic          m_udf;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_LEVEL  (AFL),
    .AE_LEVEL  (AEL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .data_counter(data_counter),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_rv   = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // Drive one cycle of requests, advance the model by the FIFO rules, then
  // leave the bench 1 ns after the edge where outputs are stable.
  task automatic step(input logic wr, input logic [DW-1:0] din,
                      input logic rd, input logic fl);
    int   sz;
    logic was_full;
    logic was_empty;
    wr_en   = wr;
    data_in = din;
    rd_en   = rd;
    flush   = fl;
    sz        = mq.size();
    was_full  = (sz == DEPTH);
    was_empty = (sz == 0);
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_rv  = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
`ifdef SYNC_FIFO_STICKY_ERR_EN
      m_ovf = m_ovf | (wr & was_full);
      m_udf = m_udf | (rd & was_empty);
`else
      m_ovf = wr & was_full;
      m_udf = rd & was_empty;
`endif
      if (rd && !was_empty) begin
        m_dout = mq.pop_front();
        m_rv   = 1'b1;
      end else begin
        m_rv = 1'b0;
      end
      if (wr && !was_full) mq.push_back(din);
    end
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    step(1'b0, '0, 1'b0, 1'b0);
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
    checks++; if (data_counter !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", data_counter); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got=%b exp=1", almost_empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      checks++; if (data_counter !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, data_counter, i + 1); end
      checks++; if (almost_full !== ((i + 1) >= AFL)) begin errors++; $display("FAIL fill_almost_full[%0d] got=%b", i, almost_full); end
      checks++; if (almost_empty !== ((i + 1) <= AEL)) begin errors++; $display("FAIL fill_almost_empty[%0d] got=%b", i, almost_empty); end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got=%b exp=1", overflow); end
    checks++; if (data_counter !== 5'd16) begin errors++; $display("FAIL overflow_count got=%0d exp=16", data_counter); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      checks++; if (data_out !== DW'(i)) begin errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, data_out, i); end
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL drain_rd_valid[%0d] got=%b exp=1", i, rd_valid); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL drain_overflow[%0d] got=%b exp=%b", i, overflow, m_ovf); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
    step(1'b0, '0, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_clears_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) step(1'b1, 32'h100 + DW'(i), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 32'h108 + DW'(k), 1'b1, 1'b0);
      checks++; if (data_counter !== 5'd8) begin errors++; $display("FAIL b2b_count[%0d] got=%0d exp=8", k, data_counter); end
      checks++; if (data_out !== 32'h100 + DW'(k)) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, data_out, 32'h100 + k); end
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_rd_valid[%0d] got=%b exp=1", k, rd_valid); end
    end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_underflow();
    logic [DW-1:0] held;
    held = m_dout;
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set got=%b exp=1", underflow); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL underflow_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (data_out !== held) begin errors++; $display("FAIL underflow_data_held got=%h exp=%h", data_out, held); end
    step(1'b0, '0, 1'b0, 1'b0);
`ifdef SYNC_FIFO_STICKY_ERR_EN
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky got=%b exp=1", underflow); end
`else
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_pulse got=%b exp=0", underflow); end
`endif
    step(1'b0, '0, 1'b0, 1'b1);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_flush got=%b exp=0", underflow); end
  endtask

  task automatic test_flush();
    logic [DW-1:0] held;
    for (int i = 0; i < 5; i++) step(1'b1, 32'h200 + DW'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    held = m_dout;
    step(1'b1, 32'h0BAD_0BAD, 1'b1, 1'b1);
    checks++; if (data_counter !== 5'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", data_counter); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b exp=1", empty); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL flush_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (data_out !== held) begin errors++; $display("FAIL flush_data_held got=%h exp=%h", data_out, held); end
    checks++; if ((overflow | underflow) !== 1'b0) begin errors++; $display("FAIL flush_errors got=%b%b exp=00", overflow, underflow); end
    step(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (data_out !== 32'hCAFE_F00D) begin errors++; $display("FAIL flush_new_word got=%h exp=cafef00d", data_out); end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL flush_new_rd_valid got=%b exp=1", rd_valid); end
  endtask

  task automatic test_random();
    logic          wr, rd, fl;
    logic [DW-1:0] d;
    int            sz;
    for (int c = 0; c < 400; c++) begin
      // Phase-dependent bias so the FIFO visits both full and empty.
      wr = ($urandom_range(0, 99) < ((c / 50) % 2 == 0 ? 75 : 30));
      rd = ($urandom_range(0, 99) < ((c / 50) % 2 == 0 ? 30 : 75));
      fl = ($urandom_range(0, 99) == 0);
      d  = $urandom;
      step(wr, d, rd, fl);
      sz = mq.size();
      checks++; if (data_counter !== 5'(sz)) begin errors++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", c, data_counter, sz); end
      checks++; if (data_out !== m_dout) begin errors++; $display("FAIL rnd_data[%0d] got=%h exp=%h", c, data_out, m_dout); end
      checks++; if (rd_valid !== m_rv) begin errors++; $display("FAIL rnd_rd_valid[%0d] got=%b exp=%b", c, rd_valid, m_rv); end
      checks++; if ({full, empty} !== {sz == DEPTH, sz == 0}) begin errors++; $display("FAIL rnd_full_empty[%0d] got=%b%b cnt=%0d", c, full, empty, sz); end
      checks++; if ({almost_full, almost_empty} !== {sz >= AFL, sz <= AEL}) begin errors++; $display("FAIL rnd_almost[%0d] got=%b%b cnt=%0d", c, almost_full, almost_empty, sz); end
      checks++; if ({overflow, underflow} !== {m_ovf, m_udf}) begin errors++; $display("FAIL rnd_errflags[%0d] got=%b%b exp=%b%b", c, overflow, underflow, m_ovf, m_udf); end
    end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 32'h300 + DW'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h309, 1'b0, 1'b0);
    checks++; if (data_counter !== 5'd9) begin errors++; $display("FAIL pre_reset_count got=%0d exp=9", data_counter); end
    // Mid-cycle assertion: outputs must clear before the next rising edge.
    #2 reset = 1'b1;
    #1;
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL areset_data_out got=%h exp=0", data_out); end
    checks++; if (data_counter !== 5'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", data_counter); end
    checks++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin errors++; $display("FAIL areset_flags got=%b%b%b%b exp=1100", empty, almost_empty, full, almost_full); end
    checks++; if ({rd_valid, overflow, underflow} !== 3'b000) begin errors++; $display("FAIL areset_status got=%b%b%b exp=000", rd_valid, overflow, underflow); end
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    step(1'b1, 32'h4444_5555, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (data_out !== 32'h4444_5555) begin errors++; $display("FAIL post_reset_data got=%h exp=44445555", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL post_reset_empty got=%b exp=1", empty); end
  endtask

  initial begin
    reset   = 1'b1;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    model_reset();
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_underflow();
    test_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
